// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: 2^INDEX_BITS lines of one 32-bit word,
// a single outstanding MemInter request per miss, pipeline flush and global stall.
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        f_valid,
  input  logic [31:0] f_addr,
  output logic        f_ready,
  output logic [31:0] f_result,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_result,
  output logic [1:0]  dbg_state
);

  // Handshakes: the Fetcher holds f_valid and f_addr until a one-cycle f_ready pulse;
  // mem_valid/mem_addr are held until a one-cycle mem_ready pulse or a flush.
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [31:2]         req_addr, req_addr_d;
  logic                f_ready_d;
  logic [31:0]         f_result_d;
  logic                mem_valid_d;
  logic [31:0]         mem_addr_d;

  logic [LINES-1:0]    line_valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  fill;
  logic                  unused_addr_bits;

  assign idx              = req_addr[INDEX_BITS+1:2];
  assign tag              = req_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign hit              = line_valid[idx] && (tag_mem[idx] == tag);
  assign fill             = rdy_in && !rob_clear && (state == MISS) && mem_ready;
  assign dbg_state        = state;
  assign unused_addr_bits = ^f_addr[1:0];

  always_comb begin
    state_d     = state;
    req_addr_d  = req_addr;
    f_ready_d   = 1'b0;
    f_result_d  = f_result;
    mem_valid_d = mem_valid;
    mem_addr_d  = mem_addr;
    if (rob_clear) begin
      state_d     = IDLE;
      mem_valid_d = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // While f_ready is high the Fetcher is still seeing the old request.
          if (f_valid && !f_ready) begin
            req_addr_d = f_addr[31:2];
            state_d    = LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            f_ready_d  = 1'b1;
            f_result_d = data_mem[idx];
            state_d    = IDLE;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr, 2'b00};
            state_d     = MISS;
          end
        end
        MISS: begin
          if (mem_ready) begin
            f_ready_d   = 1'b1;
            f_result_d  = mem_result;
            mem_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      req_addr   <= '0;
      f_ready    <= 1'b0;
      f_result   <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      line_valid <= '0;
    end else if (rdy_in) begin
      state     <= state_d;
      req_addr  <= req_addr_d;
      f_ready   <= f_ready_d;
      f_result  <= f_result_d;
      mem_valid <= mem_valid_d;
      mem_addr  <= mem_addr_d;
      if (fill) line_valid[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; line_valid alone decides whether a line is usable.
  always_ff @(posedge clk_in) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_result;
    end
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the Fetcher (upstream) and the MemInter instruction port (downstream).
- Serves 32-bit instruction words to the Fetcher; hits are answered from on-chip arrays.
- Misses issue one word request to MemInter and fill the line.
- Honours pipeline flush (rob_clear) and the global stall (rdy_in).

Parameters:
- INDEX_BITS, 7, log2 of line count (128 lines, one 32-bit word per line).
- ADDR_BITS, 18, significant address bits; tag = addr[ADDR_BITS-1 : INDEX_BITS+2].

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  stall: when low, all state and outputs freeze.
- rob_clear  input  1  flush: abort the in-flight request.
- f_valid  input  1  Fetcher request valid; held high with f_addr stable until f_ready.
- f_addr  input  32  instruction address; bits [1:0] ignored.
- f_ready  output  1  one-cycle registered pulse: f_result valid for the request.
- f_result  output  32  instruction word.
- mem_valid  output  1  request to MemInter; held until mem_ready or flush.
- mem_addr  output  32  word-aligned fetch address ({f_addr[31:2],2'b00}).
- mem_ready  input  1  one-cycle pulse: mem_result valid.
- mem_result  input  32  word returned by MemInter.

Behaviour:
- Reset (rst_in=0, async):
  - state=IDLE; f_ready=0; f_result=0; mem_valid=0; mem_addr=0.
  - All line valid bits cleared; tag and data arrays are not cleared.
- rdy_in=0: no state, register or array update; outputs hold. rob_clear and mem_ready are ignored in that cycle (MemInter is also frozen).
- Priority in an rdy_in=1 cycle: rob_clear > mem_ready > f_valid.
- States: IDLE, LOOKUP, MISS.
- IDLE:
  - If f_valid=1 and f_ready=0: latch f_addr into req_addr and go to LOOKUP.
  - f_valid is ignored while f_ready=1. This prevents re-accepting a request already being answered.
- LOOKUP: index = req_addr[INDEX_BITS+1:2]; compare valid and tag.
  - Hit: at the edge, f_ready<=1, f_result<=data[index], go to IDLE. Hit latency: f_ready is visible 2 cycles after f_valid is first sampled.
  - Miss: mem_valid<=1, mem_addr<={req_addr[31:2],2'b00}, go to MISS.
- MISS:
  - Hold mem_valid and mem_addr stable.
  - On mem_ready=1: write data/tag, set valid, f_ready<=1, f_result<=mem_result, mem_valid<=0, go to IDLE.
- f_ready is deasserted the cycle after any pulse; it is never high two cycles in a row.
- rob_clear=1 (any state):
  - Next state IDLE; f_ready<=0; mem_valid<=0.
  - No array write, even if mem_ready is also high in the same cycle.
  - Existing valid lines are retained.
  - Any request the Fetcher re-presents after the clear is treated as new.
- Address wrap: index/tag are pure bit slices. Addresses differing only above ADDR_BITS alias, which is acceptable (memory is 128KB).
- Coherence:
  - Stores never invalidate lines; self-modifying code is unsupported.
  - I/O space (addr[17:16]==2'b11) is never fetched from.
- A conflicting fill overwrites the line unconditionally (direct-mapped, no replacement state).
- At most one outstanding memory request.

Test Plan:
- Cold miss: after reset, f_valid=1, f_addr=0x0000_0004. Required: mem_valid=1 with mem_addr=0x4 one cycle after LOOKUP. mem_ready with mem_result=0x0000_0013 then gives f_ready pulse with f_result=0x13 on the next cycle and mem_valid=0.
- Hit: re-request 0x4. Required: f_ready two cycles later, f_result=0x13, mem_valid stays 0 throughout.
- Conflict: fill 0x0000_0200 (same index as 0x0, different tag) with 0xDEADBEEF, then request 0x0. Required: miss and memory request at 0x0. Then request 0x200 again: required miss (line was evicted).
- Flush mid-miss: request 0x100, assert rob_clear in the same cycle as mem_ready (mem_result=0x1234). Required: no f_ready, mem_valid=0 next cycle. A later request to 0x100 must miss.
- Stall: during MISS drop rdy_in for 5 cycles while toggling mem_ready. Required: state, mem_valid and mem_addr unchanged. After rdy_in returns, a mem_ready completes normally.
- Async reset mid-LOOKUP: pull rst_in low between clock edges. Required: f_ready=0, mem_valid=0 immediately. A subsequent request to a previously cached address misses.
